wdt_timer: RTL and testbench

- Watchdog timer on the SoC bus, directly upstream of the reset controller.
- Drives that controller's soc_fault / soc_fault_cause / soc_fault_addr inputs.
- Software must periodically write a key to KICK; if the down-counter expires while enabled, a one-cycle soc_fault pulse is issued with cause `RST_CAUSE_WDT.
- Bus slave protocol matches other femto peripherals: registered resp/rdata one cycle after req; fault is combinational in the req cycle.

---
 rtl/wdt_timer.sv | 221 ++++++++++++++++++++++
 tb/tb_wdt_timer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_timer.sv
// wdt_timer: bus-programmable watchdog timer feeding the SoC reset controller.
// Registers: CTRL(0, 2B) KICK(2, 2B) LOAD(4, 4B) COUNT(8, 4B).
// Build option WDT_PRETIMEOUT_EN adds PRE(12, 4B) and a registered irq output.

`ifndef WDT_VA_WIDTH
`define WDT_VA_WIDTH 4
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RST_CAUSE_WDT
`define RST_CAUSE_WDT 8'h03
`endif

module wdt_timer #(
  parameter int unsigned DIV       = 1024,
  parameter logic [31:0] INIT_LOAD = 32'hFFFF_FFFF,
  parameter logic [15:0] KICK_KEY  = 16'h5A5A
) (
  input  logic                      clk,
  input  logic                      rst_ib,
  input  logic [`WDT_VA_WIDTH-1:0]  addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault,
  output logic                      soc_fault,
  output logic [7:0]                soc_fault_cause,
  output logic [`XLEN-1:0]          soc_fault_addr
`ifdef WDT_PRETIMEOUT_EN
  ,
  output logic                      irq
`endif
);

  localparam int VA = `WDT_VA_WIDTH;
  localparam int BW = `BUS_WIDTH;
  localparam int XW = `XLEN;

  localparam logic [VA-1:0] OFF_CTRL  = VA'(0);
  localparam logic [VA-1:0] OFF_KICK  = VA'(2);
  localparam logic [VA-1:0] OFF_LOAD  = VA'(4);
  localparam logic [VA-1:0] OFF_COUNT = VA'(8);
`ifdef WDT_PRETIMEOUT_EN
  localparam logic [VA-1:0] OFF_PRE   = VA'(12);
`endif

  localparam logic [`BUS_ACC_WIDTH-1:0] ACC_2B = `BUS_ACC_2B;
  localparam logic [`BUS_ACC_WIDTH-1:0] ACC_4B = `BUS_ACC_4B;

  // Prescaler is 17 bits so DIV up to 65536 (last value 65535) fits.
  localparam logic [16:0] PRESC_LAST = 17'(DIV - 1);

  logic          en_reg;
  logic          lock_reg;
  logic [31:0]   load_reg;
  logic [31:0]   count_reg;
  logic [16:0]   presc_reg;

  logic          access_ok;
  logic          valid;
  logic          rd_en;
  logic          ctrl_wr;
  logic          kick_wr;
  logic          load_wr;
  logic [BW-1:0] rd_mux;

  logic          tick;
  logic          timeout;
  logic          en_next;
  logic          en_rise;
  logic [31:0]   count_next;
  logic [16:0]   presc_next;

`ifdef WDT_PRETIMEOUT_EN
  logic [31:0]   pre_reg;
  logic          pre_wr;
  logic          irq_reg;
`endif

  // Address/size/permission decode and read-data selection for the current request.
  always_comb begin
    access_ok = 1'b0;
    rd_mux    = '0;
    if (addr == OFF_CTRL && acc == ACC_2B) begin
      access_ok = !w_rb || !lock_reg;
      rd_mux    = BW'({lock_reg, en_reg});
    end else if (addr == OFF_KICK && acc == ACC_2B) begin
      access_ok = w_rb && (wdata[15:0] == KICK_KEY);
    end else if (addr == OFF_LOAD && acc == ACC_4B) begin
      access_ok = !w_rb || !lock_reg;
      rd_mux    = BW'(load_reg);
    end else if (addr == OFF_COUNT && acc == ACC_4B) begin
      access_ok = !w_rb;
      rd_mux    = BW'(count_reg);
`ifdef WDT_PRETIMEOUT_EN
    end else if (addr == OFF_PRE && acc == ACC_4B) begin
      access_ok = !w_rb || !lock_reg;
      rd_mux    = BW'(pre_reg);
`endif
    end
  end

  assign valid   = req && access_ok;
  assign fault   = req && !access_ok;
  assign rd_en   = valid && !w_rb;
  assign ctrl_wr = valid && w_rb && (addr == OFF_CTRL);
  assign kick_wr = valid && w_rb && (addr == OFF_KICK);
  assign load_wr = valid && w_rb && (addr == OFF_LOAD);
`ifdef WDT_PRETIMEOUT_EN
  assign pre_wr  = valid && w_rb && (addr == OFF_PRE);
`endif

  // Prescaler tick, timeout detection and next counter/prescaler values.
  always_comb begin
    tick       = en_reg && (presc_reg == PRESC_LAST);
    // A kick landing on the expiring tick wins and suppresses the fault.
    timeout    = tick && (count_reg == 32'd0) && !kick_wr;
    en_next    = ctrl_wr ? wdata[0] : en_reg;
    en_rise    = en_next && !en_reg;
    count_next = count_reg;
    if (kick_wr || en_rise || timeout) begin
      count_next = load_reg;
    end else if (tick) begin
      // count_reg is non-zero here: a zero count on a tick is a timeout or a kick.
      count_next = count_reg - 32'd1;
    end
    if (kick_wr || en_rise || !en_next || tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + 17'd1;
    end
  end

  // Control registers and the timer datapath.
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      en_reg    <= 1'b0;
      lock_reg  <= 1'b0;
      load_reg  <= INIT_LOAD;
      count_reg <= INIT_LOAD;
      presc_reg <= '0;
    end else begin
      en_reg    <= en_next;
      count_reg <= count_next;
      presc_reg <= presc_next;
      if (ctrl_wr) begin
        lock_reg <= lock_reg | wdata[1];
      end
      if (load_wr) begin
        load_reg <= wdata[31:0];
      end
    end
  end

  // Bus response: resp one cycle after a valid request; rdata changes only on valid reads.
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      resp <= valid;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  // One-cycle timeout report towards the reset controller.
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      soc_fault       <= 1'b0;
      soc_fault_cause <= 8'd0;
      soc_fault_addr  <= '0;
    end else begin
      soc_fault       <= timeout;
      soc_fault_cause <= timeout ? `RST_CAUSE_WDT : 8'd0;
      soc_fault_addr  <= timeout ? XW'(load_reg) : '0;
    end
  end

`ifdef WDT_PRETIMEOUT_EN
  // Pre-timeout threshold register and its sticky interrupt.
  always_ff @(posedge clk or negedge rst_ib) begin
    if (!rst_ib) begin
      pre_reg <= 32'd0;
      irq_reg <= 1'b0;
    end else begin
      if (pre_wr) begin
        pre_reg <= wdata[31:0];
      end
      if (kick_wr || !en_next || timeout) begin
        irq_reg <= 1'b0;
      end else if (en_reg && (pre_reg != 32'd0) && (count_reg <= pre_reg)) begin
        irq_reg <= 1'b1;
      end
    end
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_wdt_timer.sv
// tb_wdt_timer: table-driven register checks, directed timeout/kick/lock/reset
// sequences and a randomized run against a behavioural model of the watchdog.

`ifndef WDT_VA_WIDTH
`define WDT_VA_WIDTH 4
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RST_CAUSE_WDT
`define RST_CAUSE_WDT 8'h03
`endif

module tb_wdt_timer;
  localparam int          DIV  = 4;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] KEY  = 16'h5A5A;
  localparam logic [1:0]  A1   = `BUS_ACC_1B;
  localparam logic [1:0]  A2   = `BUS_ACC_2B;
  localparam logic [1:0]  A4   = `BUS_ACC_4B;
  localparam logic [7:0]  CAUSE = `RST_CAUSE_WDT;

  logic        clk = 1'b0;
  logic        rst_ib = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic        w_rb = 1'b0;
  logic [1:0]  acc = 2'd0;
  logic [31:0] rdata;
  logic [31:0] wdata = 32'h0;
  logic        req = 1'b0;
  logic        resp;
  logic        fault;
  logic        soc_fault;
  logic [7:0]  soc_fault_cause;
  logic [31:0] soc_fault_addr;
`ifdef WDT_PRETIMEOUT_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wdt_timer #(.DIV(DIV), .INIT_LOAD(INIT), .KICK_KEY(KEY)) dut (
    .clk(clk), .rst_ib(rst_ib), .addr(addr), .w_rb(w_rb), .acc(acc),
    .rdata(rdata), .wdata(wdata), .req(req), .resp(resp), .fault(fault),
    .soc_fault(soc_fault), .soc_fault_cause(soc_fault_cause),
    .soc_fault_addr(soc_fault_addr)
`ifdef WDT_PRETIMEOUT_EN
    , .irq(irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_en, m_lock, m_irq;
  logic [31:0] m_load, m_cnt, m_pre;
  int          m_phase;      // cycles since the prescaler last restarted
  logic        e_resp, e_sf;
  logic [31:0] e_rdata, e_addr;
  logic [7:0]  e_cause;

  task automatic model_reset();
    m_en = 0; m_lock = 0; m_irq = 0; m_load = INIT; m_cnt = INIT; m_pre = 0;
    m_phase = 0; e_resp = 0; e_sf = 0; e_rdata = 0; e_addr = 0; e_cause = 0;
  endtask

  function automatic logic m_ok(input logic w, input logic [3:0] a, input logic [1:0] s,
                                input logic [31:0] d);
    case (a)
      4'd0:  return s == A2 && (!w || !m_lock);
      4'd2:  return s == A2 && w && d[15:0] == KEY;
      4'd4:  return s == A4 && (!w || !m_lock);
      4'd8:  return s == A4 && !w;
`ifdef WDT_PRETIMEOUT_EN
      4'd12: return s == A4 && (!w || !m_lock);
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {30'd0, m_lock, m_en};
      4'd4:    return m_load;
      4'd8:    return m_cnt;
      default: return m_pre;
    endcase
  endfunction

  // Advance the model across one clock edge with the given request applied.
  task automatic model_edge(input logic rq, input logic w, input logic [3:0] a,
                            input logic [1:0] s, input logic [31:0] d);
    logic ok, kick, tick, to, nen, rise;
    ok   = rq && m_ok(w, a, s, d);
    kick = ok && w && a == 4'd2;
    tick = m_en && ((m_phase + 1) % DIV == 0);
    to   = tick && m_cnt == 0 && !kick;
    e_resp = ok;
    if (ok && !w) e_rdata = m_read(a);
    e_sf    = to;
    e_cause = to ? CAUSE : 8'd0;
    e_addr  = to ? m_load : 32'd0;
    nen  = (ok && w && a == 4'd0) ? d[0] : m_en;
    rise = nen && !m_en;
    if (kick || !nen || to) m_irq = 0;
    else if (m_en && m_pre != 0 && m_cnt <= m_pre) m_irq = 1;
    if (kick || rise || to) m_cnt = m_load;
    else if (tick && m_cnt != 0) m_cnt = m_cnt - 1;
    if (kick || rise || !nen) m_phase = 0;
    else m_phase = m_phase + 1;
    if (ok && w && a == 4'd0) m_lock = m_lock | d[1];
    if (ok && w && a == 4'd4) m_load = d;
    if (ok && w && a == 4'd12) m_pre = d;
    m_en = nen;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    req = 0; w_rb = 0;
    #2 rst_ib = 0;
    @(posedge clk); @(posedge clk);
    #3 rst_ib = 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One bus access; returns combinational fault and the registered resp/rdata.
  task automatic bus(input logic w, input logic [3:0] a, input logic [1:0] s,
                     input logic [31:0] d, output logic f, output logic r,
                     output logic [31:0] rd);
    req = 1; w_rb = w; addr = a; acc = s; wdata = d;
    #1 f = fault;
    @(posedge clk); #1;
    req = 0; w_rb = 0;
    r = resp; rd = rdata;
    $display("txn %s addr=%0h acc=%0d wdata=%h fault=%0b resp=%0b rdata=%h",
             w ? "W" : "R", a, s, d, f, r, rd);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [1:0]  s;
    logic [31:0] d;
    logic        f;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [1:0] s,
                              input logic [31:0] d, input logic f, input logic [31:0] rd);
    vec_t v;
    v.w = w; v.a = a; v.s = s; v.d = d; v.f = f; v.rd = rd;
    return v;
  endfunction

  vec_t        tbl[15];
  logic        f, r;
  logic [31:0] rd;
  logic [3:0]  picks[8] = '{4'd0, 4'd2, 4'd4, 4'd8, 4'd12, 4'd6, 4'd1, 4'd14};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // ---- reset state ----
    do_reset();
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sf", 32'(soc_fault), 32'd0);
    chk("rst_cause", 32'(soc_fault_cause), 32'd0);
    chk("rst_faddr", soc_fault_addr, 32'd0);

    // ---- table-driven register access (EN stays 0) ----
    tbl[0]  = mk(1'b0, 4'h0, A2, 32'h0,     1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 4'h4, A4, 32'h0,     1'b0, INIT);
    tbl[2]  = mk(1'b0, 4'h8, A4, 32'h0,     1'b0, INIT);
    tbl[3]  = mk(1'b0, 4'h2, A2, 32'h0,     1'b1, 32'h0);
    tbl[4]  = mk(1'b0, 4'h0, A4, 32'h0,     1'b1, 32'h0);
    tbl[5]  = mk(1'b0, 4'h6, A4, 32'h0,     1'b1, 32'h0);
    tbl[6]  = mk(1'b1, 4'h8, A4, 32'h5,     1'b1, 32'h0);
    tbl[7]  = mk(1'b1, 4'h4, A4, 32'h3,     1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 4'h4, A4, 32'h0,     1'b0, 32'h3);
    tbl[9]  = mk(1'b1, 4'h2, A2, 32'h1234,  1'b1, 32'h0);
    tbl[10] = mk(1'b1, 4'h2, A2, 32'h5A5A,  1'b0, 32'h0);
    tbl[11] = mk(1'b0, 4'h8, A4, 32'h0,     1'b0, 32'h3);
    tbl[12] = mk(1'b0, 4'h0, A1, 32'h0,     1'b1, 32'h0);
    tbl[13] = mk(1'b1, 4'h2, A4, 32'h5A5A,  1'b1, 32'h0);
`ifdef WDT_PRETIMEOUT_EN
    tbl[14] = mk(1'b0, 4'hC, A4, 32'h0,     1'b0, 32'h0);
`else
    tbl[14] = mk(1'b0, 4'hC, A4, 32'h0,     1'b1, 32'h0);
`endif
    for (int i = 0; i < 15; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, f, r, rd);
      chk($sformatf("tbl%0d_fault", i), 32'(f), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_resp", i), 32'(r), 32'(!tbl[i].f));
      if (!tbl[i].w && !tbl[i].f) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end

    // ---- bad key leaves counter; LOAD write does not touch running counter ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd5, f, r, rd);
    bus(1'b1, 4'h2, A2, 32'h5A5A, f, r, rd);
    bus(1'b1, 4'h4, A4, 32'd9, f, r, rd);
    bus(1'b1, 4'h2, A2, 32'h1234, f, r, rd);
    chk("badkey_fault", 32'(f), 32'd1);
    chk("badkey_resp", 32'(r), 32'd0);
    bus(1'b0, 4'h8, A4, 32'd0, f, r, rd);
    chk("badkey_count", rd, 32'd5);

    // ---- timeout period: DIV=4, LOAD=3 -> pulse every 16 cycles ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd3, f, r, rd);
    bus(1'b1, 4'h0, A2, 32'd1, f, r, rd);
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      chk($sformatf("to_pulse_c%0d", c), 32'(soc_fault), 32'(c == 16 || c == 32));
      if (c == 16) begin
        chk("to_cause", 32'(soc_fault_cause), 32'(CAUSE));
        chk("to_addr", soc_fault_addr, 32'd3);
      end
    end

    // ---- regular kicks keep the watchdog quiet ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd3, f, r, rd);
    bus(1'b1, 4'h0, A2, 32'd1, f, r, rd);
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 9; j++) begin
        @(posedge clk); #1;
        chk("kick_quiet", 32'(soc_fault), 32'd0);
      end
      bus(1'b1, 4'h2, A2, 32'h5A5A, f, r, rd);
      chk("kick_resp", 32'(r), 32'd1);
      chk("kick_quiet", 32'(soc_fault), 32'd0);
    end

    // ---- lock ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd3, f, r, rd);
    bus(1'b1, 4'h0, A2, 32'd3, f, r, rd);
    chk("lock_set_resp", 32'(r), 32'd1);
    bus(1'b1, 4'h4, A4, 32'd7, f, r, rd);
    chk("lock_load_fault", 32'(f), 32'd1);
    bus(1'b0, 4'h4, A4, 32'd0, f, r, rd);
    chk("lock_load_val", rd, 32'd3);
    bus(1'b1, 4'h0, A2, 32'd0, f, r, rd);
    chk("lock_ctrl_fault", 32'(f), 32'd1);
    bus(1'b0, 4'h0, A2, 32'd0, f, r, rd);
    chk("lock_ctrl_val", rd, 32'd3);

    // ---- kick on the exact timeout tick, then async reset mid-count ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd3, f, r, rd);
    bus(1'b1, 4'h0, A2, 32'd1, f, r, rd);
    idle(15);
    bus(1'b1, 4'h2, A2, 32'h5A5A, f, r, rd);
    chk("race_sf", 32'(soc_fault), 32'd0);
    bus(1'b0, 4'h8, A4, 32'd0, f, r, rd);
    chk("race_count", rd, 32'd3);
    chk("race_sf2", 32'(soc_fault), 32'd0);
    #2 rst_ib = 0;
    #1;
    chk("async_resp", 32'(resp), 32'd0);
    chk("async_rdata", rdata, 32'd0);
    chk("async_sf", 32'(soc_fault), 32'd0);
    @(posedge clk);
    #3 rst_ib = 1;
    @(posedge clk); #1;
    bus(1'b0, 4'h8, A4, 32'd0, f, r, rd);
    chk("async_count", rd, INIT);

`ifdef WDT_PRETIMEOUT_EN
    // ---- pre-timeout interrupt: LOAD=10, PRE=4, DIV=4 ----
    do_reset();
    bus(1'b1, 4'h4, A4, 32'd10, f, r, rd);
    bus(1'b1, 4'hC, A4, 32'd4, f, r, rd);
    bus(1'b1, 4'h0, A2, 32'd1, f, r, rd);
    for (int c = 1; c <= 69; c++) begin
      @(posedge clk); #1;
      if (c == 24) chk("irq_before", 32'(irq), 32'd0);
      if (c == 25) chk("irq_rise", 32'(irq), 32'd1);
      if (c == 44) begin
        chk("irq_sf", 32'(soc_fault), 32'd1);
        chk("irq_clr_to", 32'(irq), 32'd0);
      end
      if (c == 69) chk("irq_again", 32'(irq), 32'd1);
    end
    bus(1'b1, 4'h2, A2, 32'h5A5A, f, r, rd);
    chk("irq_clr_kick", 32'(irq), 32'd0);
`endif

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rq, w;
      logic [3:0]  a;
      logic [1:0]  s;
      logic [31:0] d;
      if (i % 600 == 599) begin
        do_reset();
        model_reset();
      end
      rq = ($urandom_range(0, 9) < 6);
      a  = picks[$urandom_range(0, 7)];
      s  = (a == 4'd0 || a == 4'd2) ? A2 : A4;
      if ($urandom_range(0, 4) == 0) s = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      case (a)
        4'd0:  d = {30'd0, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0)};
        4'd2:  if ($urandom_range(0, 4) != 0) d[15:0] = KEY;
        4'd4:  d = $urandom_range(0, 12);
        4'd12: d = $urandom_range(0, 6);
        default: ;
      endcase
      req = rq; w_rb = w; addr = a; acc = s; wdata = d;
      #1;
      chk("rnd_fault", 32'(fault), 32'(rq && !m_ok(w, a, s, d)));
      model_edge(rq, w, a, s, d);
      @(posedge clk); #1;
      req = 0;
      if (rq) $display("txn rnd %s addr=%0h acc=%0d wdata=%h resp=%0b rdata=%h",
                       w ? "W" : "R", a, s, d, resp, rdata);
      chk("rnd_resp", 32'(resp), 32'(e_resp));
      chk("rnd_rdata", rdata, e_rdata);
      chk("rnd_sf", 32'(soc_fault), 32'(e_sf));
      chk("rnd_cause", 32'(soc_fault_cause), 32'(e_cause));
      chk("rnd_faddr", soc_fault_addr, e_addr);
`ifdef WDT_PRETIMEOUT_EN
      chk("rnd_irq", 32'(irq), 32'(m_irq));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
